// File: rtl/regfile_rs_pkg.sv
// Shared constants and types for the renaming register file.
// Reset/write polarities, default geometry and the read-source selector.
package regfile_rs_pkg;

  localparam logic RstEnable   = 1'b1;
  localparam logic RstDisable  = 1'b0;
  localparam logic WriteEnable = 1'b1;

  localparam int RegNum     = 32;
  localparam int RegNumLog2 = 5;
  localparam int RsTagBus   = 4;

  localparam logic [RsTagBus-1:0] ZeroTag = 4'b0000;

  typedef enum logic [1:0] {
    SRC_ZERO   = 2'd0,
    SRC_BYPASS = 2'd1,
    SRC_BUSY   = 2'd2,
    SRC_REG    = 2'd3
  } rd_src_e;

endpackage

// File: rtl/regfile_rs_reg_status_table.sv
// Per-register busy bit and producer tag with issue/clear/flush handling,
// plus a registered count of busy registers.
module reg_status_table
  import regfile_rs_pkg::*;
#(
  parameter int NREG = RegNum,
  parameter int AW   = RegNumLog2,
  parameter int TAGW = RsTagBus
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 iss_en,
  input  logic [AW-1:0]        iss_addr,
  input  logic [TAGW-1:0]      iss_tag,
  input  logic                 wb_en,
  input  logic [AW-1:0]        wb_addr,
  input  logic [TAGW-1:0]      wb_tag,
  input  logic                 flush,
  output logic [NREG-1:0]      busy,
  output logic [NREG*TAGW-1:0] tag,
  output logic [AW:0]          busy_cnt
);

  logic [NREG-1:0]      busy_r;
  logic [NREG-1:0]      busy_nxt_s;
  logic [NREG*TAGW-1:0] tag_r;
  logic [NREG*TAGW-1:0] tag_nxt_s;
  logic [AW:0]          busy_cnt_r;

  function automatic logic [AW:0] popcount(input logic [NREG-1:0] v);
    logic [AW:0] c;
    c = {(AW+1){1'b0}};
    for (int i = 0; i < NREG; i++) begin
      c = c + {{AW{1'b0}}, v[i]};
    end
    return c;
  endfunction

  // Next status: flush beats issue, issue beats a matching writeback clear.
  always_comb begin
    busy_nxt_s = busy_r;
    tag_nxt_s  = tag_r;
    for (int i = 1; i < NREG; i++) begin
      if (flush == WriteEnable) begin
        busy_nxt_s[i]              = 1'b0;
        tag_nxt_s[i*TAGW +: TAGW]  = {TAGW{1'b0}};
      end else if (iss_en && (iss_addr == AW'(i))) begin
        busy_nxt_s[i]              = 1'b1;
        tag_nxt_s[i*TAGW +: TAGW]  = iss_tag;
      end else if (wb_en && (wb_addr == AW'(i)) && busy_r[i] &&
                   (tag_r[i*TAGW +: TAGW] == wb_tag)) begin
        busy_nxt_s[i]              = 1'b0;
        tag_nxt_s[i*TAGW +: TAGW]  = {TAGW{1'b0}};
      end else begin
        busy_nxt_s[i]              = busy_r[i];
        tag_nxt_s[i*TAGW +: TAGW]  = tag_r[i*TAGW +: TAGW];
      end
    end
    busy_nxt_s[0]          = 1'b0;
    tag_nxt_s[TAGW-1:0]    = {TAGW{1'b0}};
  end

  // Status and busy count registers.
  always_ff @(posedge clk) begin
    if (rst == RstEnable) begin
      busy_r     <= {NREG{1'b0}};
      tag_r      <= {(NREG*TAGW){1'b0}};
      busy_cnt_r <= {(AW+1){1'b0}};
    end else begin
      busy_r     <= busy_nxt_s;
      tag_r      <= tag_nxt_s;
      busy_cnt_r <= popcount(busy_nxt_s);
    end
  end

  assign busy     = busy_r;
  assign tag      = tag_r;
  assign busy_cnt = busy_cnt_r;

endmodule

// File: rtl/regfile_rs.sv
// Register file with rename status: NRD combinational read ports returning
// committed data or busy+producer tag, one issue port and a bypassing writeback.
module regfile_rs
  import regfile_rs_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int NREG = RegNum,
  parameter int AW   = RegNumLog2,
  parameter int NRD  = 2,
  parameter int TAGW = RsTagBus
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NRD*AW-1:0]    rd_addr,
  output logic [NRD*XLEN-1:0]  rd_data,
  output logic [NRD-1:0]       rd_busy,
  output logic [NRD*TAGW-1:0]  rd_tag,
  input  logic                 iss_en,
  input  logic [AW-1:0]        iss_addr,
  input  logic [TAGW-1:0]      iss_tag,
  input  logic                 wb_en,
  input  logic [AW-1:0]        wb_addr,
  input  logic [XLEN-1:0]      wb_data,
  input  logic [TAGW-1:0]      wb_tag,
  input  logic                 flush,
  output logic [AW:0]          busy_cnt
);

  logic [XLEN-1:0]      regs_r [NREG];
  logic [NREG-1:0]      busy_s;
  logic [NREG*TAGW-1:0] tag_s;

  logic [AW-1:0]        addr_s      [NRD];
  logic [XLEN-1:0]      cell_data_s [NRD];
  logic                 cell_busy_s [NRD];
  logic [TAGW-1:0]      cell_tag_s  [NRD];
  logic                 cell_hit_s  [NRD];
  rd_src_e              src_s       [NRD];

  reg_status_table #(
    .NREG (NREG),
    .AW   (AW),
    .TAGW (TAGW)
  ) u_status (
    .clk      (clk),
    .rst      (rst),
    .iss_en   (iss_en),
    .iss_addr (iss_addr),
    .iss_tag  (iss_tag),
    .wb_en    (wb_en),
    .wb_addr  (wb_addr),
    .wb_tag   (wb_tag),
    .flush    (flush),
    .busy     (busy_s),
    .tag      (tag_s),
    .busy_cnt (busy_cnt)
  );

  // Data array: writeback always lands, independent of busy/tag state.
  always_ff @(posedge clk) begin
    if (rst == RstEnable) begin
      for (int i = 0; i < NREG; i++) begin
        regs_r[i] <= {XLEN{1'b0}};
      end
    end else begin
      regs_r[0] <= {XLEN{1'b0}};
      for (int i = 1; i < NREG; i++) begin
        if (wb_en && (wb_addr == AW'(i))) begin
          regs_r[i] <= wb_data;
        end else begin
          regs_r[i] <= regs_r[i];
        end
      end
    end
  end

  // One-hot lookup of the addressed cell; no hit means out-of-range address.
  always_comb begin
    for (int k = 0; k < NRD; k++) begin
      addr_s[k]      = rd_addr[k*AW +: AW];
      cell_data_s[k] = {XLEN{1'b0}};
      cell_busy_s[k] = 1'b0;
      cell_tag_s[k]  = {TAGW{1'b0}};
      cell_hit_s[k]  = 1'b0;
      for (int i = 0; i < NREG; i++) begin
        cell_hit_s[k]  = cell_hit_s[k] | (addr_s[k] == AW'(i));
        cell_data_s[k] = cell_data_s[k] | (regs_r[i] & {XLEN{addr_s[k] == AW'(i)}});
        cell_busy_s[k] = cell_busy_s[k] | (busy_s[i] & (addr_s[k] == AW'(i)));
        cell_tag_s[k]  = cell_tag_s[k] | (tag_s[i*TAGW +: TAGW] & {TAGW{addr_s[k] == AW'(i)}});
      end
    end
  end

  // Per-port source priority and output mux; the status seen is pre-edge.
  always_comb begin
    rd_data = {(NRD*XLEN){1'b0}};
    rd_busy = {NRD{1'b0}};
    rd_tag  = {(NRD*TAGW){1'b0}};
    for (int k = 0; k < NRD; k++) begin
      if (!cell_hit_s[k] || (addr_s[k] == {AW{1'b0}})) begin
        src_s[k] = SRC_ZERO;
      end else if (wb_en && (wb_addr == addr_s[k]) && cell_busy_s[k] &&
                   (cell_tag_s[k] == wb_tag)) begin
        src_s[k] = SRC_BYPASS;
      end else if (cell_busy_s[k]) begin
        src_s[k] = SRC_BUSY;
      end else begin
        src_s[k] = SRC_REG;
      end

      if (rst == RstEnable) begin
        rd_data[k*XLEN +: XLEN] = {XLEN{1'b0}};
        rd_busy[k]              = 1'b0;
        rd_tag[k*TAGW +: TAGW]  = {TAGW{1'b0}};
      end else begin
        case (src_s[k])
          SRC_BYPASS: begin
            rd_data[k*XLEN +: XLEN] = wb_data;
            rd_busy[k]              = 1'b0;
            rd_tag[k*TAGW +: TAGW]  = {TAGW{1'b0}};
          end
          SRC_BUSY: begin
            rd_data[k*XLEN +: XLEN] = cell_data_s[k];
            rd_busy[k]              = 1'b1;
            rd_tag[k*TAGW +: TAGW]  = cell_tag_s[k];
          end
          SRC_REG: begin
            rd_data[k*XLEN +: XLEN] = cell_data_s[k];
            rd_busy[k]              = 1'b0;
            rd_tag[k*TAGW +: TAGW]  = {TAGW{1'b0}};
          end
          default: begin
            rd_data[k*XLEN +: XLEN] = {XLEN{1'b0}};
            rd_busy[k]              = 1'b0;
            rd_tag[k*TAGW +: TAGW]  = {TAGW{1'b0}};
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_regfile_rs.sv
// Bench for regfile_rs: directed vector table followed by random traffic
// checked against an array-based reference model.
module tb_regfile_rs;

  localparam int XLEN = 32;
  localparam int NREG = 32;
  localparam int AW   = 5;
  localparam int NRD  = 2;
  localparam int TAGW = 4;

  logic                clk;
  logic                rst;
  logic [NRD*AW-1:0]   rd_addr;
  logic [NRD*XLEN-1:0] rd_data;
  logic [NRD-1:0]      rd_busy;
  logic [NRD*TAGW-1:0] rd_tag;
  logic                iss_en;
  logic [AW-1:0]       iss_addr;
  logic [TAGW-1:0]     iss_tag;
  logic                wb_en;
  logic [AW-1:0]       wb_addr;
  logic [XLEN-1:0]     wb_data;
  logic [TAGW-1:0]     wb_tag;
  logic                flush;
  logic [AW:0]         busy_cnt;

  regfile_rs #(
    .XLEN(XLEN), .NREG(NREG), .AW(AW), .NRD(NRD), .TAGW(TAGW)
  ) dut (
    .clk(clk), .rst(rst), .rd_addr(rd_addr), .rd_data(rd_data),
    .rd_busy(rd_busy), .rd_tag(rd_tag), .iss_en(iss_en),
    .iss_addr(iss_addr), .iss_tag(iss_tag), .wb_en(wb_en),
    .wb_addr(wb_addr), .wb_data(wb_data), .wb_tag(wb_tag),
    .flush(flush), .busy_cnt(busy_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Reference state: plain arrays of architectural value, busy flag and tag.
  logic [XLEN-1:0] m_regs [NREG];
  logic            m_busy [NREG];
  logic [TAGW-1:0] m_tag  [NREG];

  typedef struct {
    logic            rst;
    logic            ie;
    logic [AW-1:0]   ia;
    logic [TAGW-1:0] it;
    logic            we;
    logic [AW-1:0]   wa;
    logic [XLEN-1:0] wd;
    logic [TAGW-1:0] wt;
    logic            fl;
    logic [AW-1:0]   a0;
    logic [AW-1:0]   a1;
    logic [XLEN-1:0] d0;
    logic            b0;
    logic [TAGW-1:0] t0;
    logic [XLEN-1:0] d1;
    logic            b1;
    logic [TAGW-1:0] t1;
    logic [AW:0]     cnt;
  } vec_t;

  vec_t vecs [20];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic model_read(input logic [AW-1:0] a, output logic [XLEN-1:0] d,
                            output logic b, output logic [TAGW-1:0] t);
    int ai;
    ai = int'(a);
    d = '0; b = 1'b0; t = '0;
    if (rst || ai == 0 || ai >= NREG) begin
      d = '0;
    end else if (wb_en && wb_addr == a && m_busy[ai] && m_tag[ai] == wb_tag) begin
      d = wb_data;
    end else begin
      d = m_regs[ai];
      b = m_busy[ai];
      t = m_busy[ai] ? m_tag[ai] : '0;
    end
  endtask

  task automatic model_step();
    int wa, ia;
    wa = int'(wb_addr);
    ia = int'(iss_addr);
    if (rst) begin
      for (int i = 0; i < NREG; i++) begin
        m_regs[i] = '0; m_busy[i] = 1'b0; m_tag[i] = '0;
      end
    end else begin
      if (wb_en && wa != 0 && wa < NREG) begin
        m_regs[wa] = wb_data;
        if (m_busy[wa] && m_tag[wa] == wb_tag) begin
          m_busy[wa] = 1'b0; m_tag[wa] = '0;
        end
      end
      if (flush) begin
        for (int i = 0; i < NREG; i++) begin
          m_busy[i] = 1'b0; m_tag[i] = '0;
        end
      end else if (iss_en && ia != 0 && ia < NREG) begin
        m_busy[ia] = 1'b1; m_tag[ia] = iss_tag;
      end
    end
  endtask

  function automatic int model_count();
    int c;
    c = 0;
    for (int i = 0; i < NREG; i++) c += int'(m_busy[i]);
    return c;
  endfunction

  initial begin
    logic [XLEN-1:0] ed;
    logic eb;
    logic [TAGW-1:0] et;

    for (int i = 0; i < NREG; i++) begin
      m_regs[i] = '0; m_busy[i] = 1'b0; m_tag[i] = '0;
    end
    rst = 1'b1; rd_addr = '0; iss_en = 1'b0; iss_addr = '0; iss_tag = '0;
    wb_en = 1'b0; wb_addr = '0; wb_data = '0; wb_tag = '0; flush = 1'b0;

    //          rst ie ia it  we wa wd            wt fl a0 a1 d0            b0 t0 d1            b1 t1 cnt
    vecs[0]  = '{1, 0, 0, 0,  0, 0, 32'h0,        0, 0, 1, 2, 32'h0,        0, 0, 32'h0,        0, 0, 0};
    vecs[1]  = '{0, 0, 0, 0,  1, 0, 32'hFFFF_FFFF,0, 0, 1, 0, 32'h0,        0, 0, 32'h0,        0, 0, 0};
    vecs[2]  = '{0, 1, 5, 3,  0, 0, 32'h0,        0, 0, 2, 0, 32'h0,        0, 0, 32'h0,        0, 0, 1};
    vecs[3]  = '{0, 0, 0, 0,  0, 0, 32'h0,        0, 0, 5, 0, 32'h0,        1, 3, 32'h0,        0, 0, 1};
    vecs[4]  = '{0, 0, 0, 0,  1, 5, 32'h1234,     3, 0, 5, 5, 32'h1234,     0, 0, 32'h1234,     0, 0, 0};
    vecs[5]  = '{0, 1, 7, 2,  0, 0, 32'h0,        0, 0, 5, 7, 32'h1234,     0, 0, 32'h0,        0, 0, 1};
    vecs[6]  = '{0, 1, 7, 6,  0, 0, 32'h0,        0, 0, 7, 0, 32'h0,        1, 2, 32'h0,        0, 0, 1};
    vecs[7]  = '{0, 0, 0, 0,  1, 7, 32'hAA,       2, 0, 7, 0, 32'h0,        1, 6, 32'h0,        0, 0, 1};
    vecs[8]  = '{0, 0, 0, 0,  1, 9, 32'h55,       0, 0, 7, 9, 32'hAA,       1, 6, 32'h0,        0, 0, 1};
    vecs[9]  = '{0, 1, 9, 4,  1, 7, 32'hBB,       6, 0, 7, 9, 32'hBB,       0, 0, 32'h55,       0, 0, 1};
    vecs[10] = '{0, 1, 3, 1,  0, 0, 32'h0,        0, 0, 7, 9, 32'hBB,       0, 0, 32'h55,       1, 4, 2};
    vecs[11] = '{0, 1, 3, 5,  1, 3, 32'h33,       1, 0, 3, 9, 32'h33,       0, 0, 32'h55,       1, 4, 2};
    vecs[12] = '{0, 1, 1, 1,  0, 0, 32'h0,        0, 0, 3, 0, 32'h33,       1, 5, 32'h0,        0, 0, 3};
    vecs[13] = '{0, 1, 2, 2,  0, 0, 32'h0,        0, 0, 1, 0, 32'h0,        1, 1, 32'h0,        0, 0, 4};
    vecs[14] = '{0, 1, 4, 7,  0, 0, 32'h0,        0, 0, 2, 4, 32'h0,        1, 2, 32'h0,        0, 0, 5};
    vecs[15] = '{0, 1, 8, 8,  1, 4, 32'h44,       0, 1, 4, 9, 32'h0,        1, 7, 32'h55,       1, 4, 0};
    vecs[16] = '{0, 0, 0, 0,  0, 0, 32'h0,        0, 0, 8, 4, 32'h0,        0, 0, 32'h44,       0, 0, 0};
    vecs[17] = '{0, 1, 6, 9,  0, 0, 32'h0,        0, 0, 3, 6, 32'h33,       0, 0, 32'h0,        0, 0, 1};
    vecs[18] = '{1, 0, 0, 0,  0, 0, 32'h0,        0, 0, 3, 6, 32'h0,        0, 0, 32'h0,        0, 0, 0};
    vecs[19] = '{0, 0, 0, 0,  0, 0, 32'h0,        0, 0, 3, 6, 32'h0,        0, 0, 32'h0,        0, 0, 0};

    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      rst = vecs[i].rst; iss_en = vecs[i].ie; iss_addr = vecs[i].ia; iss_tag = vecs[i].it;
      wb_en = vecs[i].we; wb_addr = vecs[i].wa; wb_data = vecs[i].wd; wb_tag = vecs[i].wt;
      flush = vecs[i].fl; rd_addr = {vecs[i].a1, vecs[i].a0};
      #1;
      chk($sformatf("vec%0d_data0", i), 64'(rd_data[XLEN-1:0]), 64'(vecs[i].d0));
      chk($sformatf("vec%0d_busy0", i), 64'(rd_busy[0]), 64'(vecs[i].b0));
      chk($sformatf("vec%0d_tag0", i), 64'(rd_tag[TAGW-1:0]), 64'(vecs[i].t0));
      chk($sformatf("vec%0d_data1", i), 64'(rd_data[2*XLEN-1:XLEN]), 64'(vecs[i].d1));
      chk($sformatf("vec%0d_busy1", i), 64'(rd_busy[1]), 64'(vecs[i].b1));
      chk($sformatf("vec%0d_tag1", i), 64'(rd_tag[2*TAGW-1:TAGW]), 64'(vecs[i].t1));
      @(posedge clk);
      model_step();
      #1;
      chk($sformatf("vec%0d_busy_cnt", i), 64'(busy_cnt), 64'(vecs[i].cnt));
    end

    // Random traffic biased toward low addresses and matching tags to hit collisions.
    for (int n = 0; n < 1500; n++) begin
      logic [AW-1:0] a0, a1;
      @(negedge clk);
      rst      = ($urandom_range(99) == 0);
      flush    = ($urandom_range(24) == 0);
      iss_en   = $urandom_range(1) == 1;
      iss_addr = AW'($urandom_range(1) == 1 ? $urandom_range(7) : $urandom_range(NREG-1));
      iss_tag  = TAGW'($urandom_range((1 << TAGW) - 1));
      wb_en    = $urandom_range(1) == 1;
      wb_addr  = AW'($urandom_range(1) == 1 ? $urandom_range(7) : $urandom_range(NREG-1));
      wb_data  = $urandom;
      wb_tag   = ($urandom_range(3) != 0) ? m_tag[int'(wb_addr)]
                                          : TAGW'($urandom_range((1 << TAGW) - 1));
      a0 = AW'($urandom_range(2) == 0 ? int'(wb_addr) : $urandom_range(7));
      a1 = AW'($urandom_range(2) == 0 ? int'(iss_addr) : $urandom_range(NREG-1));
      rd_addr = {a1, a0};
      #1;
      model_read(a0, ed, eb, et);
      chk($sformatf("rnd%0d_port0", n), 64'({rd_data[XLEN-1:0], rd_busy[0], rd_tag[TAGW-1:0]}),
          64'({ed, eb, et}));
      model_read(a1, ed, eb, et);
      chk($sformatf("rnd%0d_port1", n),
          64'({rd_data[2*XLEN-1:XLEN], rd_busy[1], rd_tag[2*TAGW-1:TAGW]}), 64'({ed, eb, et}));
      @(posedge clk);
      model_step();
      #1;
      chk($sformatf("rnd%0d_busy_cnt", n), 64'(busy_cnt), 64'(model_count()));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
